exu_alu_sched: RTL and testbench

Two-requester scheduler for the shared single-cycle integer ALU in the execute unit. It accepts ALU operations from two issue sources (slot 0, slot 1), buffers one pending operation per source, and grants the ALU round-robin. It drives the ALU's valid and operand-capture enable and returns a tagged completion to the owning source one cycle after issue. Operations are held under freeze and discarded on flush.

---
 rtl/exu_alu_sched_if.sv | 39 +++
 rtl/exu_alu_sched.sv | 118 +++++++++++
 tb/tb_exu_alu_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/exu_alu_sched_if.sv
// Issue-side bus of the execute-unit ALU scheduler: the two request slots,
// the ALU issue strobe and the two tagged completion channels.
interface exu_alu_sched_if #(
   parameter int TAGW = 4
);
   // reqN_valid may rise at any time, and the tag must stay stable while valid
   // is high. A transfer happens on a rising edge where valid & ready are both
   // high. ready depends only on registered state. alu_* and rspN_* are
   // single-cycle pulses that have no back-pressure.
   logic            req0_valid;
   logic [TAGW-1:0] req0_tag;
   logic            req0_ready;
   logic            req1_valid;
   logic [TAGW-1:0] req1_tag;
   logic            req1_ready;

   logic            alu_valid;
   logic            alu_enable;
   logic            alu_sel;

   logic            rsp0_valid;
   logic [TAGW-1:0] rsp0_tag;
   logic            rsp1_valid;
   logic [TAGW-1:0] rsp1_tag;

   modport master (
      output req0_valid, req0_tag, req1_valid, req1_tag,
      input  req0_ready, req1_ready,
      input  alu_valid, alu_enable, alu_sel,
      input  rsp0_valid, rsp0_tag, rsp1_valid, rsp1_tag
   );

   modport slave (
      input  req0_valid, req0_tag, req1_valid, req1_tag,
      output req0_ready, req1_ready,
      output alu_valid, alu_enable, alu_sel,
      output rsp0_valid, rsp0_tag, rsp1_valid, rsp1_tag
   );
endinterface

// File: rtl/exu_alu_sched.sv
// Two-slot round-robin scheduler for the shared single-cycle ALU. It keeps one
// holding entry per slot and a one-deep stage that returns tagged completions.
module exu_alu_sched #(
   parameter int TAGW = 4,
   parameter int CNTW = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                flush,
   exu_alu_sched_if.slave      bus,
   output logic                busy,
   output logic [CNTW-1:0]     issued_cnt
);

   logic            hv0;
   logic            hv1;
   logic [TAGW-1:0] ht0;
   logic [TAGW-1:0] ht1;
   logic            rr;
   logic            s1_v;
   logic            s1_src;
   logic [TAGW-1:0] s1_tag;

   logic            acc0;
   logic            acc1;
   logic            rsp_fire;
   logic            grant_ok;
   logic            both_pending;
   logic            grant;
   logic            grant_sel;
   logic [TAGW-1:0] grant_tag;

   assign acc0 = bus.req0_valid & ~hv0 & ~flush;
   assign acc1 = bus.req1_valid & ~hv1 & ~flush;

   // Stage 1 drains in the same cycle that it is refilled, so one issue per
   // cycle is sustained while no freeze is applied.
   assign rsp_fire     = s1_v & ~freeze & ~flush;
   assign grant_ok     = ~freeze & ~flush & (~s1_v | rsp_fire);
   assign both_pending = hv0 & hv1;
   assign grant        = grant_ok & (hv0 | hv1);
   assign grant_sel    = both_pending ? rr : hv1;
   assign grant_tag    = grant_sel ? ht1 : ht0;

   always_ff @(posedge clk) begin
      if (rst) begin
         hv0        <= 1'b0;
         hv1        <= 1'b0;
         ht0        <= '0;
         ht1        <= '0;
         rr         <= 1'b0;
         s1_v       <= 1'b0;
         s1_src     <= 1'b0;
         s1_tag     <= '0;
         issued_cnt <= '0;
      end else begin
         if (acc0) begin
            ht0 <= bus.req0_tag;
         end
         if (acc1) begin
            ht1 <= bus.req1_tag;
         end

         // Accept and grant of the same slot cannot coincide, because accept needs ~hvN.
         if (flush) begin
            hv0 <= 1'b0;
         end else if (acc0) begin
            hv0 <= 1'b1;
         end else if (grant && !grant_sel) begin
            hv0 <= 1'b0;
         end

         if (flush) begin
            hv1 <= 1'b0;
         end else if (acc1) begin
            hv1 <= 1'b1;
         end else if (grant && grant_sel) begin
            hv1 <= 1'b0;
         end

         // The pointer moves only when it breaks a tie.
         if (grant && both_pending) begin
            rr <= ~rr;
         end

         if (flush) begin
            s1_v <= 1'b0;
         end else if (grant) begin
            s1_v   <= 1'b1;
            s1_src <= grant_sel;
            s1_tag <= grant_tag;
         end else if (rsp_fire) begin
            s1_v <= 1'b0;
         end

         if (grant) begin
            issued_cnt <= issued_cnt + CNTW'(1);
         end
      end
   end

   assign bus.req0_ready = ~hv0;
   assign bus.req1_ready = ~hv1;

   assign bus.alu_valid  = grant;
   assign bus.alu_enable = grant;
   assign bus.alu_sel    = grant & grant_sel;

   // Tags are zeroed when their channel is idle, so a stale tag never reaches the slots.
   assign bus.rsp0_valid = rsp_fire & ~s1_src;
   assign bus.rsp1_valid = rsp_fire & s1_src;
   assign bus.rsp0_tag   = bus.rsp0_valid ? s1_tag : '0;
   assign bus.rsp1_tag   = bus.rsp1_valid ? s1_tag : '0;

   assign busy = hv0 | hv1 | s1_v;

endmodule

// File: tb/tb_exu_alu_sched.sv
// Randomized and directed bench for exu_alu_sched against a queue-based model
// of the scheduling rules (CNTW=4 build so the issue counter wraps).
module tb_exu_alu_sched;
   localparam int TAGW = 4;
   localparam int CNTW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            freeze;
   logic            flush;
   logic            busy;
   logic [CNTW-1:0] issued_cnt;

   exu_alu_sched_if #(.TAGW(TAGW)) bus ();

   exu_alu_sched #(.TAGW(TAGW), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rst        (rst),
      .freeze     (freeze),
      .flush      (flush),
      .bus        (bus),
      .busy       (busy),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   // The reference model keeps one queue of waiting tags per slot, a queue of
   // issued {src,tag} operations still owed a completion, the tie priority and the issue count.
   logic [TAGW-1:0] pend0[$];
   logic [TAGW-1:0] pend1[$];
   logic [TAGW:0]   exp_q[$];
   int              prio;
   int              cnt;
   logic            after_rst;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check the outputs against the model, then advance the model.
   task automatic step(input logic r, input logic fz, input logic fl,
                       input logic v0, input logic [TAGW-1:0] t0,
                       input logic v1, input logic [TAGW-1:0] t1,
                       output logic acc0, output logic acc1);
      logic            comp;
      logic            issue;
      logic            both;
      int              w;
      logic [TAGW:0]   head;
      logic            e_rsp0;
      logic            e_rsp1;
      logic            rdy0;
      logic            rdy1;

      @(negedge clk);
      rst            = r;
      freeze         = fz;
      flush          = fl;
      bus.req0_valid = v0;
      bus.req0_tag   = t0;
      bus.req1_valid = v1;
      bus.req1_tag   = t1;
      #1;

      rdy0   = (pend0.size() == 0);
      rdy1   = (pend1.size() == 0);
      comp   = (exp_q.size() != 0) && !fz && !fl;
      issue  = !fz && !fl && (!rdy0 || !rdy1);
      both   = !rdy0 && !rdy1;
      w      = both ? prio : (!rdy0 ? 0 : 1);
      head   = comp ? exp_q[0] : '0;
      e_rsp0 = comp && (head[TAGW] == 1'b0);
      e_rsp1 = comp && (head[TAGW] == 1'b1);

      check("req0_ready", 32'(bus.req0_ready), 32'(rdy0));
      check("req1_ready", 32'(bus.req1_ready), 32'(rdy1));
      check("alu_valid", 32'(bus.alu_valid), 32'(issue));
      check("alu_enable", 32'(bus.alu_enable), 32'(issue));
      check("alu_sel", 32'(bus.alu_sel), issue ? 32'(w) : 32'd0);
      check("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_rsp0));
      check("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_rsp1));
      if (e_rsp0 || after_rst) check("rsp0_tag", 32'(bus.rsp0_tag), e_rsp0 ? 32'(head[TAGW-1:0]) : 32'd0);
      if (e_rsp1 || after_rst) check("rsp1_tag", 32'(bus.rsp1_tag), e_rsp1 ? 32'(head[TAGW-1:0]) : 32'd0);
      check("busy", 32'(busy), 32'(!rdy0 || !rdy1 || exp_q.size() != 0));
      check("issued_cnt", 32'(issued_cnt), 32'(cnt));

      acc0 = 1'b0;
      acc1 = 1'b0;
      if (r) begin
         pend0.delete();
         pend1.delete();
         exp_q.delete();
         prio = 0;
         cnt  = 0;
      end else if (fl) begin
         pend0.delete();
         pend1.delete();
         exp_q.delete();
      end else begin
         if (comp) void'(exp_q.pop_front());
         if (issue) begin
            if (w == 0) exp_q.push_back({1'b0, pend0.pop_front()});
            else        exp_q.push_back({1'b1, pend1.pop_front()});
            if (both) prio = 1 - prio;
            cnt = (cnt + 1) % (1 << CNTW);
         end
         if (v0 && rdy0) begin
            pend0.push_back(t0);
            acc0 = 1'b1;
         end
         if (v1 && rdy1) begin
            pend1.push_back(t1);
            acc1 = 1'b1;
         end
      end
      after_rst = r;
   endtask

   task automatic idle(input int n);
      logic a0, a1;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
   endtask

   // Both slots offer tags back to back. A tag is held until that slot accepts it.
   task automatic stream(input int n, input int tag_base);
      logic a0, a1;
      int   n0, n1;
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, TAGW'(tag_base + n0), 1'b1, TAGW'(tag_base + n1 + 8), a0, a1);
         if (a0) n0++;
         if (a1) n1++;
      end
   endtask

   initial begin
      logic a0, a1;
      int   fz_pct, fl_pct;

      pend0.delete();
      pend1.delete();
      exp_q.delete();
      prio      = 0;
      cnt       = 0;
      after_rst = 1'b0;
      rst       = 1'b1;
      freeze    = 1'b0;
      flush     = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req0_tag   = '0;
      bus.req1_valid = 1'b0;
      bus.req1_tag   = '0;

      // Reset, then a lone slot-0 op with tag 3.
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
      idle(1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, '0, a0, a1);
      idle(3);

      // Both slots stream, and grants alternate from rr.
      stream(20, 0);
      idle(4);

      // Load both entries, then freeze for 3 cycles.
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 4'd6, a0, a1);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, '0, a0, a1);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
      idle(5);

      // Flush while both entries and stage 1 are occupied, then a normal issue.
      stream(6, 2);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 4'd10, a0, a1);
      idle(2);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd12, a0, a1);
      idle(3);

      // Flush and freeze together: the flush takes effect.
      stream(5, 4);
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, a0, a1);
      idle(2);

      // Reset with stage 1 full under freeze, then a tie goes to slot 0.
      stream(5, 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, a0, a1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd2, a0, a1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 1'b1, 4'd14, a0, a1);
      idle(4);

      // Drive past the 4-bit counter wrap.
      stream(40, 3);
      idle(3);

      // Random traffic that varies the freeze/flush density in each phase.
      for (int ph = 0; ph < 6; ph++) begin
         fz_pct = $urandom_range(0, 30);
         fl_pct = $urandom_range(0, 8);
         for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 999) < 3,
                 $urandom_range(0, 99) < fz_pct,
                 $urandom_range(0, 99) < fl_pct,
                 1'($urandom_range(0, 1)), TAGW'($urandom),
                 1'($urandom_range(0, 1)), TAGW'($urandom),
                 a0, a1);
         end
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
